rv32i_imem_loader: RTL and testbench

Write-side companion to the instruction memory: accepts a little-endian byte stream over a valid/ready handshake, packs bytes into 32-bit instruction words and writes them sequentially into the instruction memory's write port starting at byte address 0. Sits between the host/debug link and the instruction memory, and holds the CPU core in reset (`cpu_hold`) until a complete image has been loaded.

---
 rtl/rv32i_imem_loader_pkg.sv | 32 +++
 rtl/rv32i_imem_loader_byte_packer.sv | 35 +++
 rtl/rv32i_imem_loader.sv | 148 ++++++++++++++
 tb/tb_rv32i_imem_loader.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/rv32i_imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: memory geometry
// defaults, loader state encodings and the bytes-per-word constant.
`ifndef INSTR_MEM_DEPTH
`define INSTR_MEM_DEPTH 256
`endif
`ifndef INSTR_MEM_WIDTH
`define INSTR_MEM_WIDTH 8
`endif

package rv32i_imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        LDR_IDLE  = 3'd0,
        LDR_LEN   = 3'd1,
        LDR_DATA  = 3'd2,
        LDR_WRITE = 3'd3,
        LDR_CHK   = 3'd4,
        LDR_DONE  = 3'd5,
        LDR_ERR   = 3'd6
    } ldr_state_e;

    function automatic logic ldr_is_busy(input ldr_state_e s);
        return (s == LDR_LEN) || (s == LDR_DATA) || (s == LDR_WRITE) || (s == LDR_CHK);
    endfunction

    function automatic logic ldr_takes_bytes(input ldr_state_e s);
        return (s == LDR_LEN) || (s == LDR_DATA) || (s == LDR_CHK);
    endfunction

endpackage

// File: rtl/rv32i_imem_loader_byte_packer.sv
// Little-endian byte-to-word packer: 2-bit lane counter plus assembly register;
// word_valid_o fires combinationally with the 4th byte, presenting the full word.
module rv32i_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [7:0]  data_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [1:0]  cnt_q;
    logic [23:0] asm_q;

    // The top byte is never stored: it is forwarded directly with the 4th byte.
    assign word_o       = {data_i, asm_q};
    assign word_valid_o = en_i && (cnt_q == 2'd3);

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            cnt_q <= 2'd0;
            asm_q <= 24'd0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 2'd1;
            case (cnt_q)
                2'd0:    asm_q[7:0]   <= data_i;
                2'd1:    asm_q[15:8]  <= data_i;
                2'd2:    asm_q[23:16] <= data_i;
                default: asm_q        <= asm_q;
            endcase
        end
    end

endmodule

// File: rtl/rv32i_imem_loader.sv
// Streams a length-prefixed little-endian image into instruction memory and
// holds the core in reset until done. RV32I_IMEM_LOADER_CHECKSUM_EN adds a sum trailer.
`ifndef INSTR_MEM_DEPTH
`define INSTR_MEM_DEPTH 256
`endif
`ifndef INSTR_MEM_WIDTH
`define INSTR_MEM_WIDTH 8
`endif

module rv32i_imem_loader
    import rv32i_imem_loader_pkg::*;
#(
    parameter int DEPTH = `INSTR_MEM_DEPTH,
    parameter int AW    = `INSTR_MEM_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          mem_we,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          cpu_hold,
    output logic [AW:0]   words_loaded
);

    ldr_state_e    state_q, state_d;
    logic [31:0]   n_q;
    logic [AW-1:0] idx_q;
    logic [AW:0]   words_q;
    logic          in_ready_q, mem_we_q, busy_q, done_q, err_q, hold_q;
    logic [31:0]   mem_addr_q, mem_wdata_q;
`ifdef RV32I_IMEM_LOADER_CHECKSUM_EN
    logic [31:0]   sum_q;
`endif

    logic        xfer, start_ok, last_word, pk_valid;
    logic [31:0] pk_word, word_addr;

    assign xfer      = in_valid && in_ready_q;
    assign start_ok  = start && ((state_q == LDR_IDLE) || (state_q == LDR_DONE) || (state_q == LDR_ERR));
    assign last_word = ((32'(idx_q) + 32'd1) == n_q);
    assign word_addr = 32'({idx_q, 2'b00});

    rv32i_byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (start_ok),
        .en_i         (xfer),
        .data_i       (in_data),
        .word_o       (pk_word),
        .word_valid_o (pk_valid)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            LDR_IDLE, LDR_DONE, LDR_ERR: if (start) state_d = LDR_LEN;
            LDR_LEN: begin
                if (pk_valid) begin
                    if (pk_word == 32'd0)              state_d = LDR_DONE;
                    else if (pk_word > 32'(DEPTH))     state_d = LDR_ERR;
                    else                               state_d = LDR_DATA;
                end
            end
            LDR_DATA: if (pk_valid) state_d = LDR_WRITE;
            LDR_WRITE: begin
`ifdef RV32I_IMEM_LOADER_CHECKSUM_EN
                state_d = last_word ? LDR_CHK : LDR_DATA;
`else
                state_d = last_word ? LDR_DONE : LDR_DATA;
`endif
            end
            LDR_CHK: begin
`ifdef RV32I_IMEM_LOADER_CHECKSUM_EN
                if (pk_valid) state_d = (pk_word == sum_q) ? LDR_DONE : LDR_ERR;
`else
                state_d = LDR_IDLE;
`endif
            end
            default: state_d = LDR_IDLE;
        endcase
    end

    // Every output flag is registered from the next state so it lines up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LDR_IDLE;
            n_q         <= 32'd0;
            idx_q       <= '0;
            words_q     <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            hold_q      <= 1'b1;
`ifdef RV32I_IMEM_LOADER_CHECKSUM_EN
            sum_q       <= 32'd0;
`endif
        end else begin
            state_q    <= state_d;
            in_ready_q <= ldr_takes_bytes(state_d);
            mem_we_q   <= (state_d == LDR_WRITE);
            busy_q     <= ldr_is_busy(state_d);
            done_q     <= (state_d == LDR_DONE);
            err_q      <= (state_d == LDR_ERR);
            hold_q     <= (state_d != LDR_DONE);
            if (start_ok) begin
                idx_q   <= '0;
                words_q <= '0;
`ifdef RV32I_IMEM_LOADER_CHECKSUM_EN
                sum_q   <= 32'd0;
`endif
            end
            if ((state_q == LDR_LEN) && pk_valid) n_q <= pk_word;
            if ((state_q == LDR_DATA) && pk_valid) begin
                mem_wdata_q <= pk_word;
                mem_addr_q  <= word_addr;
            end
            if (state_q == LDR_WRITE) begin
                idx_q   <= idx_q + 1'b1;
                words_q <= words_q + 1'b1;
`ifdef RV32I_IMEM_LOADER_CHECKSUM_EN
                sum_q   <= sum_q + mem_wdata_q;
`endif
            end
        end
    end

    assign in_ready     = in_ready_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign cpu_hold     = hold_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_rv32i_imem_loader.sv
// Scoreboard bench for rv32i_imem_loader: expected writes are queued as bytes
// are driven and checked when mem_we fires; one line printed per write.
module tb_rv32i_imem_loader;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst, start, in_valid;
    logic [7:0]    in_data;
    logic          in_ready, mem_we, busy, done, err, cpu_hold;
    logic [31:0]   mem_addr, mem_wdata;
    logic [AW:0]   words_loaded;

    rv32i_imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err(err), .cpu_hold(cpu_hold), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_we = -1;
    bit          chk_spacing = 1'b0;
    logic [31:0] img [0:7];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (mem_we === 1'b1) begin
            $display("write cyc=%0d addr=%h data=%h", cyc, mem_addr, mem_wdata);
            check("rdy_in_write", 32'(in_ready), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_we", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", mem_addr, e.addr);
                check("wr_data", mem_wdata, e.data);
            end
            if (chk_spacing && last_we >= 0) check("wr_spacing", 32'(cyc - last_we), 32'd5);
            last_we = cyc;
        end
    end

    task automatic check_reset_values();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst_words", 32'(words_loaded), 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (in_ready !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (t >= 40) begin
            check("ready_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit rnd);
        for (int i = 0; i < 4; i++)
            send_byte(w[8*i +: 8], rnd ? int'($urandom_range(0, 3)) : 0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_in_ready", 32'(in_ready), 32'd1);
        check("start_busy", 32'(busy), 32'd1);
        check("start_hold", 32'(cpu_hold), 32'd1);
        check("start_done", 32'(done), 32'd0);
    endtask

    // exp_end: 0 = DONE, 1 = ERR
    task automatic run_load(input int n, input bit rnd, input logic [31:0] trailer_delta,
                            input int exp_end, input int exp_words, input bit send_data);
        logic [31:0] sum;
        int t;
        sum = 32'd0;
        pulse_start();
        send_word(32'(n), rnd);
        if (send_data) begin
            for (int i = 0; i < n; i++) begin
                exp_q.push_back({32'(i * 4), img[i]});
                sum = sum + img[i];
                send_word(img[i], rnd);
            end
`ifdef RV32I_IMEM_LOADER_CHECKSUM_EN
            if (n > 0) send_word(sum + trailer_delta, rnd);
`endif
        end
        t = 0;
        while (!(done === 1'b1 || err === 1'b1) && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("end_timeout", 32'(t < 50), 32'd1);
        check("end_done", 32'(done), 32'(exp_end == 0));
        check("end_err", 32'(err), 32'(exp_end == 1));
        check("end_hold", 32'(cpu_hold), 32'(exp_end != 0));
        check("end_busy", 32'(busy), 32'd0);
        check("end_words", 32'(words_loaded), 32'(exp_words));
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("load n=%0d done=%0b err=%0b words=%0d", n, done, err, words_loaded);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_values();

        img[0] = 32'h0000_0013;
        run_load(1, 1'b0, 32'd0, 0, 1, 1'b1);

        img[0] = 32'h0050_0093; img[1] = 32'h00A0_0113; img[2] = 32'h0020_81B3;
        last_we = -1; chk_spacing = 1'b1;
        run_load(3, 1'b0, 32'd0, 0, 3, 1'b1);
        chk_spacing = 1'b0;

        run_load(0, 1'b0, 32'd0, 0, 0, 1'b1);
        run_load(DEPTH + 1, 1'b0, 32'd0, 1, 0, 1'b0);

        img[0] = 32'hDEAD_BEEF; img[1] = 32'h1234_5678; img[2] = 32'h0000_0001; img[3] = 32'hFFFF_FFFF;
        run_load(4, 1'b1, 32'd0, 0, 4, 1'b1);

        // Abort after six data bytes of a two-word image; only word 0 gets written.
        img[0] = 32'hA5A5_0001; img[1] = 32'h5A5A_0002;
        pulse_start();
        send_word(32'd2, 1'b0);
        exp_q.push_back({32'd0, img[0]});
        send_word(img[0], 1'b0);
        send_byte(img[1][7:0], 0);
        send_byte(img[1][15:8], 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values();
        check("rst_sb_empty", 32'(exp_q.size()), 32'd0);

        img[0] = 32'h0010_0073;
        run_load(1, 1'b0, 32'd0, 0, 1, 1'b1);

`ifdef RV32I_IMEM_LOADER_CHECKSUM_EN
        img[0] = 32'd1; img[1] = 32'd2;
        run_load(2, 1'b0, 32'd0, 0, 2, 1'b1);
        run_load(2, 1'b0, 32'd1, 1, 2, 1'b1);
`endif

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
